// File: rtl/seg_value_encoder.sv
// seg_value_encoder
//   Converts a binary value (0..99) into two 7-segment digit patterns for the
//   time-multiplexed digit driver. A sequential shift-add-3 (double-dabble)
//   conversion runs for WIDTH cycles, then a registered segment encode updates
//   the output. Values above 99 skip the conversion and show two dashes.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN -- blank the tens digit when it
//   is zero on the normal path (the ones digit and the dashes are never blanked).
//
// Parameters
//   WIDTH      input value width, 7..10
//   DONE_PULSE 1: done is a single-cycle pulse; 0: done holds until next accept
//
// Ports
//   clk       system clock, all state on posedge
//   rst       asynchronous active-low reset
//   in_value  binary value to display
//   in_valid  in_value is valid
//   in_ready  block can accept; transfer when in_valid & in_ready at posedge
//   both7seg  {tens[6:0], ones[6:0]}, per digit {g,f,e,d,c,b,a}, 1 = lit
//   done      both7seg has been updated
//   ovf       last accepted value was greater than 99
module seg_value_encoder #(
  parameter int WIDTH      = 7,
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [13:0]      both7seg,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ENCODE
  } state_t;

  localparam logic [WIDTH-1:0] MAX_IN   = WIDTH'(99);
  localparam logic [3:0]       CNT_LAST = 4'(WIDTH - 1);
  localparam logic [6:0]       SEG_DASH = 7'h40;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_path_q, ovf_path_d;
  logic [13:0]      seg_q, seg_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       tens_adj, ones_adj;
  logic [6:0]       tens_pat;
  logic             accept;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_ready && in_valid;

  // Add-3 correction happens before the shift so a nibble >= 5 carries
  // correctly into the next decimal place.
  assign tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
  assign ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign tens_pat = (tens_q == 4'd0) ? 7'h00 : seg_of(tens_q);
`else
  assign tens_pat = seg_of(tens_q);
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    ovf_path_d = ovf_path_q;
    seg_d      = seg_q;
    ovf_d      = ovf_q;
    done_d     = DONE_PULSE ? 1'b0 : done_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          done_d = 1'b0;
          if (in_value > MAX_IN) begin
            ovf_path_d = 1'b1;
            state_d    = S_ENCODE;
          end else begin
            ovf_path_d = 1'b0;
            shreg_d    = in_value;
            tens_d     = 4'd0;
            ones_d     = 4'd0;
            cnt_d      = 4'd0;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        {tens_d, ones_d, shreg_d} = {tens_adj, ones_adj, shreg_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (ovf_path_q) begin
          seg_d = {SEG_DASH, SEG_DASH};
          ovf_d = 1'b1;
        end else begin
          seg_d = {tens_pat, seg_of(ones_q)};
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      cnt_q      <= 4'd0;
      ovf_path_q <= 1'b0;
      seg_q      <= 14'h0000;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      ovf_path_q <= ovf_path_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign both7seg = seg_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule
